// File: rtl/rgb_chain_pkg.sv
// rgb_chain_pkg: FSM states, GRB field offsets and ns-to-cycle rounding for the RGB chain driver
package rgb_chain_pkg;
  typedef enum logic [1:0] {IDLE, FETCH, SEND, LATCH} state_t;
  localparam int G_OFS = 16;
  localparam int R_OFS = 8;
  localparam int B_OFS = 0;
  localparam int PIX_MSB = G_OFS + 7;
  function automatic int ns_to_cyc(input longint clk_hz, input longint ns);
    return int'((clk_hz / 1000 * ns + 500_000) / 1_000_000);
  endfunction
endpackage

// File: rtl/rgb_bit_encoder.sv
// rgb_bit_encoder: strobe loads one bit; drives dat high T1H/T0H cycles then low to BIT_CYC, bit_done on last cycle
module rgb_bit_encoder #(
  parameter int BIT_CYC = 63,
  parameter int T0H_CYC = 20,
  parameter int T1H_CYC = 40
) (
  input  logic clk,
  input  logic rst,
  input  logic strobe,
  input  logic bit_val,
  output logic dat,
  output logic bit_done
);
  localparam int CW = $clog2(BIT_CYC + 1);
  logic [CW-1:0] cnt, hi;
  logic active;
  assign bit_done = active && cnt == CW'(BIT_CYC - 1);
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      active <= 1'b0;
      cnt <= '0;
      hi <= '0;
      dat <= 1'b0;
    end else if (strobe) begin
      active <= 1'b1;
      cnt <= '0;
      hi <= bit_val ? CW'(T1H_CYC) : CW'(T0H_CYC);
      dat <= 1'b1;
    end else if (active) begin
      cnt <= cnt + 1'b1;
      dat <= (cnt + 1'b1) < hi;
      active <= !bit_done;
    end
endmodule

// File: rtl/rgb_chain_driver.sv
// rgb_chain_driver: frames NUM_LEDS GRB pixels (PIX_DATA/PIX_VALID/PIX_READY) onto RGB_DAT with prefetch, underrun abort and latch gap (BUSY/DONE/UNDERRUN)
module rgb_chain_driver
  import rgb_chain_pkg::*;
#(
  parameter int CLK_HZ   = 50_000_000,
  parameter int NUM_LEDS = 8,
  parameter int T0H_NS   = 400,
  parameter int T1H_NS   = 800,
  parameter int BIT_NS   = 1250,
  parameter int RESET_US = 80
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        START,
  input  logic [23:0] PIX_DATA,
  input  logic        PIX_VALID,
  output logic        PIX_READY,
  output logic        RGB_DAT,
  output logic        BUSY,
  output logic        DONE,
  output logic        UNDERRUN
);
  localparam int T0H_CYC = ns_to_cyc(CLK_HZ, T0H_NS);
  localparam int T1H_CYC = ns_to_cyc(CLK_HZ, T1H_NS);
  localparam int BIT_CYC = ns_to_cyc(CLK_HZ, BIT_NS);
  localparam int RESET_CYC = ns_to_cyc(CLK_HZ, RESET_US * 1000);
  localparam int UNDERRUN_CYC = RESET_CYC / 2;
  localparam int NW = $clog2(NUM_LEDS + 1);
  localparam int UW = $clog2(UNDERRUN_CYC + 1);
  localparam int LW = $clog2(RESET_CYC + 1);
  state_t state;
  logic [23:0] hold, shift;
  logic full, strobe, bit_val, bit_done, last, take;
  logic [NW-1:0] req, sent, sent_nx;
  logic [4:0] bit_idx;
  logic [UW-1:0] wait_cnt;
  logic [LW-1:0] latch_cnt;
  always_comb begin
    last = bit_idx == 5'(B_OFS);
    sent_nx = sent + 1'b1;
    strobe = (state == FETCH && full) ||
             (state == SEND && bit_done && (!last || (sent_nx != NW'(NUM_LEDS) && full)));
    bit_val = (state == SEND && !last) ? shift[PIX_MSB-1] : hold[PIX_MSB];
    PIX_READY = !full && BUSY && req < NW'(NUM_LEDS);
    take = PIX_VALID && PIX_READY;
  end
  always_ff @(posedge CLK or posedge RST)
    if (RST) begin
      state <= IDLE;
      hold <= '0;
      shift <= '0;
      full <= 1'b0;
      req <= '0;
      sent <= '0;
      bit_idx <= '0;
      wait_cnt <= '0;
      latch_cnt <= '0;
      BUSY <= 1'b0;
      DONE <= 1'b0;
      UNDERRUN <= 1'b0;
    end else begin
      DONE <= 1'b0;
      UNDERRUN <= 1'b0;
      if (take) begin
        hold <= PIX_DATA;
        full <= 1'b1;
        req <= req + 1'b1;
      end
      case (state)
        IDLE: if (START) begin
          state <= FETCH;
          BUSY <= 1'b1;
          full <= 1'b0;
          req <= '0;
          sent <= '0;
          wait_cnt <= '0;
        end
        FETCH: if (full) begin
          shift <= hold;
          full <= 1'b0;
          bit_idx <= 5'(PIX_MSB);
          state <= SEND;
        end else if (wait_cnt == UW'(UNDERRUN_CYC - 1)) begin
          // abandon the frame: saturating req keeps PIX_READY low and drops any same-cycle load
          UNDERRUN <= 1'b1;
          req <= NW'(NUM_LEDS);
          full <= 1'b0;
          latch_cnt <= '0;
          state <= LATCH;
        end else wait_cnt <= wait_cnt + 1'b1;
        SEND: if (bit_done) begin
          if (!last) begin
            shift <= shift << 1;
            bit_idx <= bit_idx - 1'b1;
          end else begin
            sent <= sent_nx;
            if (sent_nx == NW'(NUM_LEDS)) begin
              latch_cnt <= '0;
              state <= LATCH;
            end else if (full) begin
              shift <= hold;
              full <= 1'b0;
              bit_idx <= 5'(PIX_MSB);
            end else begin
              wait_cnt <= '0;
              state <= FETCH;
            end
          end
        end
        LATCH: if (latch_cnt == LW'(RESET_CYC - 1)) begin
          state <= IDLE;
          BUSY <= 1'b0;
          DONE <= 1'b1;
        end else latch_cnt <= latch_cnt + 1'b1;
      endcase
    end
  rgb_bit_encoder #(.BIT_CYC(BIT_CYC), .T0H_CYC(T0H_CYC), .T1H_CYC(T1H_CYC)) enc (
    .clk(CLK),
    .rst(RST),
    .strobe(strobe),
    .bit_val(bit_val),
    .dat(RGB_DAT),
    .bit_done(bit_done)
  );
endmodule
